// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with frame-based debounce
//
// Drives one keypad column low at a time, samples the synchronized rows at the
// end of each column's dwell, assembles a 16-key frame, reduces it to a single
// candidate code and debounces that candidate over whole frames.
//
// Parameters:
//   SCAN_DIV        clocks each column is driven (>= 4)
//   DEBOUNCE_FRAMES identical frames needed to accept a press or a release (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   row[3:0]   keypad rows, active-low, asynchronous
//   col[3:0]   keypad columns, active-low, exactly one low
//   key[3:0]   debounced key code, 0 = no key
//   key_valid  one-cycle pulse when key changes to a nonzero code
//   key_held   high while a debounced key is accepted
//
// Build option:
//   KEYPAD_MULTIKEY_REJECT_EN  when defined, frames with two or more mapped
//                              keys pressed yield candidate 0 instead of the
//                              first key in row-major order.

module keypad_scan #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_DONE = MW'(DEBOUNCE_FRAMES);
    localparam logic [MW-1:0] MATCH_ONE  = MW'(1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    // Scanner state
    logic [3:0]    row_meta_q;
    logic [3:0]    row_sync_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    col_idx_q;
    logic [15:0]   pressed_q;   // bit r*4+c set when row r / col c was seen low
    logic          eval_q;      // frame complete, evaluate candidate this cycle

    // Debounce state
    state_t        state_q, state_d;
    logic [3:0]    stored_q, stored_d;
    logic [MW-1:0] match_q, match_d;
    logic [3:0]    key_q, key_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;

    logic [3:0]    cand;
    logic [MW-1:0] match_inc;

    function automatic logic [3:0] key_code(input int idx);
        case (idx)
            0:  key_code = 4'd1;
            1:  key_code = 4'd2;
            2:  key_code = 4'd3;
            3:  key_code = 4'd11;
            4:  key_code = 4'd4;
            5:  key_code = 4'd5;
            6:  key_code = 4'd6;
            7:  key_code = 4'd12;
            8:  key_code = 4'd7;
            9:  key_code = 4'd8;
            10: key_code = 4'd9;
            11: key_code = 4'd13;
            13: key_code = 4'd10;
            14: key_code = 4'd15;
            15: key_code = 4'd14;
            default: key_code = 4'd0;   // r3c0 is not mapped
        endcase
    endfunction

    assign col = ~(4'b0001 << col_idx_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            dwell_q    <= '0;
            col_idx_q  <= 2'd0;
            pressed_q  <= '0;
            eval_q     <= 1'b0;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            eval_q     <= 1'b0;
            if (dwell_q == DWELL_LAST) begin
                dwell_q   <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                for (int c = 0; c < 4; c++) begin
                    if (col_idx_q == 2'(c)) begin
                        for (int r = 0; r < 4; r++) begin
                            pressed_q[r*4 + c] <= ~row_sync_q[r];
                        end
                    end
                end
                // The last column's sample completes the frame; evaluate next clock
                eval_q <= (col_idx_q == 2'd3);
            end else begin
                dwell_q <= dwell_q + DW'(1);
            end
        end
    end

    // Descending scan so the lowest row-major index wins
    always_comb begin
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        logic [4:0] n_mapped;
        n_mapped = 5'd0;
`endif
        cand = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pressed_q[i] && (key_code(i) != 4'd0)) begin
                cand = key_code(i);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
                n_mapped = n_mapped + 5'd1;
`endif
            end
        end
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        if (n_mapped > 5'd1) begin
            cand = 4'd0;
        end
`endif
    end

    assign match_inc = match_q + MW'(1);

    always_comb begin
        state_d  = state_q;
        stored_d = stored_q;
        match_d  = match_q;
        key_d    = key_q;
        held_d   = held_q;
        valid_d  = 1'b0;
        if (eval_q) begin
            case (state_q)
                RELEASED: begin
                    if (cand != 4'd0) begin
                        stored_d = cand;
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d = PRESSED;
                            key_d   = cand;
                            held_d  = 1'b1;
                            valid_d = 1'b1;
                            match_d = '0;
                        end else begin
                            state_d = PRESS_WAIT;
                            match_d = MATCH_ONE;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (cand == 4'd0) begin
                        state_d = RELEASED;
                        match_d = '0;
                    end else if (cand == stored_q) begin
                        if (match_inc == MATCH_DONE) begin
                            state_d = PRESSED;
                            key_d   = stored_q;
                            held_d  = 1'b1;
                            valid_d = 1'b1;
                            match_d = '0;
                        end else begin
                            match_d = match_inc;
                        end
                    end else begin
                        stored_d = cand;
                        match_d  = MATCH_ONE;
                    end
                end
                PRESSED: begin
                    // Any nonzero candidate, even a different key, keeps the
                    // accepted key; a new key must follow a full release.
                    if (cand == 4'd0) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d = RELEASED;
                            key_d   = 4'd0;
                            held_d  = 1'b0;
                            match_d = '0;
                        end else begin
                            state_d = RELEASE_WAIT;
                            match_d = MATCH_ONE;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (cand == 4'd0) begin
                        if (match_inc == MATCH_DONE) begin
                            state_d = RELEASED;
                            key_d   = 4'd0;
                            held_d  = 1'b0;
                            match_d = '0;
                        end else begin
                            match_d = match_inc;
                        end
                    end else begin
                        state_d = PRESSED;
                        match_d = '0;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    match_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RELEASED;
            stored_q <= 4'd0;
            match_q  <= '0;
            key_q    <= 4'd0;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stored_q <= stored_d;
            match_q  <= match_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            held_q   <= held_d;
        end
    end

    assign key       = key_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_FRAMES=2)

module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = 16'h0000;   // bit r*4+c: key at row r / col c held down

    int vectors     = 0;
    int miscompares = 0;

    int codes [16] = '{1, 2, 3, 11, 4, 5, 6, 12, 7, 8, 9, 13, 0, 10, 15, 14};

    int  hist [$];
    int  m_key       = 0;
    bit  m_held      = 1'b0;
    int  m_valid_cnt = 0;
    int  dut_valid_cnt = 0;

    always #5 clk = ~clk;

    // Passive keypad: a pressed key shorts its row to its column
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col[c] && keys[r*4 + c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    keypad_scan #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always @(negedge clk) begin
        if (key_valid) begin
            dut_valid_cnt++;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cand_of(input logic [15:0] m);
        int first;
        int n;
        first = 0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (m[i] && codes[i] != 0) begin
                if (n == 0) first = codes[i];
                n++;
            end
        end
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        if (n >= 2) first = 0;
`endif
        return first;
    endfunction

    // Accept when the last DF candidates since the previous transition are one
    // nonzero code; release when the last DF candidates are all zero.
    task automatic model_frame(input int c, output bit accepted);
        int  n;
        bit  ok;
        accepted = 1'b0;
        hist.push_back(c);
        n = hist.size();
        if (n >= DF) begin
            ok = 1'b1;
            for (int i = 0; i < DF; i++) begin
                if (m_held) begin
                    if (hist[n-1-i] != 0) ok = 1'b0;
                end else begin
                    if (hist[n-1-i] != hist[n-1] || hist[n-1] == 0) ok = 1'b0;
                end
            end
            if (ok && !m_held) begin
                m_key    = hist[n-1];
                m_held   = 1'b1;
                accepted = 1'b1;
                m_valid_cnt++;
                hist.delete();
            end else if (ok && m_held) begin
                m_key  = 0;
                m_held = 1'b0;
                hist.delete();
            end
        end
    endtask

    // Entered one clock into a frame; leaves one clock into the next frame,
    // just after the key register has taken this frame's result.
    task automatic frame(input logic [15:0] ks, input string tag);
        bit         acc;
        logic [3:0] ec;
        keys = ks;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            ec = ~(4'b0001 << (((i + 1) / SD) % 4));
            check("col", {4'd0, col}, {4'd0, ec});
        end
        model_frame(cand_of(ks), acc);
        check({tag, "_key"},   {4'd0, key},      8'(m_key));
        check({tag, "_held"},  {7'd0, key_held}, {7'd0, m_held});
        check({tag, "_valid"}, {7'd0, key_valid}, {7'd0, acc});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_key",   {4'd0, key},       8'd0);
        check("rst_col",   {4'd0, col},       8'h0E);
        check("rst_held",  {7'd0, key_held},  8'd0);
        check("rst_valid", {7'd0, key_valid}, 8'd0);
        rst = 1'b0;
        hist.delete();
        m_key  = 0;
        m_held = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ks;
        int          hold;
        int          sel;

        keys = 16'h0000;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Idle scanning
        frame(16'h0000, "idle");
        frame(16'h0000, "idle");

        // r1c2 held steadily
        frame(16'h0040, "r1c2_f1");
        check("r1c2_pending", {4'd0, key}, 8'd0);
        frame(16'h0040, "r1c2_f2");
        check("r1c2_accept", {4'd0, key}, 8'd6);
        frame(16'h0040, "r1c2_f3");
        frame(16'h0000, "r1c2_rel1");
        frame(16'h0000, "r1c2_rel2");
        check("r1c2_released", {4'd0, key}, 8'd0);

        // r3c3 bounce then real press
        frame(16'h8000, "r3c3_bounce");
        frame(16'h0000, "r3c3_gap1");
        frame(16'h0000, "r3c3_gap2");
        check("r3c3_bounce_key", {4'd0, key}, 8'd0);
        frame(16'h8000, "r3c3_f1");
        frame(16'h8000, "r3c3_f2");
        check("r3c3_accept", {4'd0, key}, 8'd14);
        frame(16'h0000, "r3c3_rel1");
        frame(16'h0000, "r3c3_rel2");

        // r0c0 with a one-frame release glitch
        frame(16'h0001, "r0c0_f1");
        frame(16'h0001, "r0c0_f2");
        frame(16'h0000, "r0c0_glitch");
        frame(16'h0001, "r0c0_f3");
        frame(16'h0001, "r0c0_f4");
        check("r0c0_kept", {4'd0, key}, 8'd1);
        frame(16'h0000, "r0c0_rel1");
        frame(16'h0000, "r0c0_rel2");
        check("r0c0_released", {4'd0, key}, 8'd0);
        check("r0c0_held_off", {7'd0, key_held}, 8'd0);

        // r0c1 and r2c3 together
        frame(16'h0802, "multi_f1");
        frame(16'h0802, "multi_f2");
        frame(16'h0802, "multi_f3");
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        check("multi_key", {4'd0, key}, 8'd0);
`else
        check("multi_key", {4'd0, key}, 8'd2);
`endif
        frame(16'h0000, "multi_rel1");
        frame(16'h0000, "multi_rel2");

        // Reset while r2c0 is accepted, key kept down throughout
        frame(16'h0100, "r2c0_f1");
        frame(16'h0100, "r2c0_f2");
        check("r2c0_accept", {4'd0, key}, 8'd7);
        do_reset();
        frame(16'h0100, "r2c0_post1");
        check("r2c0_post1_key", {4'd0, key}, 8'd0);
        frame(16'h0100, "r2c0_post2");
        check("r2c0_reaccept", {4'd0, key}, 8'd7);
        frame(16'h0000, "r2c0_rel1");
        frame(16'h0000, "r2c0_rel2");

        // Random key patterns held for 1..3 frames
        for (int s = 0; s < 30; s++) begin
            sel = $urandom_range(0, 3);
            ks  = 16'h0000;
            if (sel == 1 || sel == 2) begin
                ks[$urandom_range(0, 15)] = 1'b1;
            end else if (sel == 3) begin
                ks[$urandom_range(0, 15)] = 1'b1;
                ks[$urandom_range(0, 15)] = 1'b1;
            end
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) begin
                frame(ks, "rand");
            end
        end
        frame(16'h0000, "final_rel1");
        frame(16'h0000, "final_rel2");

        check("valid_pulses", 8'(dut_valid_cnt), 8'(m_valid_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter: SCAN_DIV, default 50000, clocks each column is driven (1 ms at 50 MHz); legal values >= 4.
REQ-002 Parameter: DEBOUNCE_FRAMES, default 5, consecutive identical frames needed to accept a press or release; legal values >= 1.
REQ-003 Port: clk  input  1  system clock; all logic rising-edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: row  input  4  keypad rows, active-low, externally pulled up, asynchronous.
REQ-006 Port: col  output  4  keypad columns, active-low, exactly one bit low at any time.
REQ-007 Port: key  output  4  debounced key code, 0 = no key; feeds the calculator usrin input directly.
REQ-008 Port: key_valid  output  1  one-cycle pulse when key changes to a nonzero code.
REQ-009 Port: key_held  output  1  high while a debounced key is accepted.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer before any use.
REQ-011 A dwell counter SHALL count 0..SCAN_DIV-1; on wrap, col SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-012 Rows SHALL be sampled from the synchronizer output on dwell count SCAN_DIV-1 of each column; four samples form one frame.
REQ-013 Key map, row r / col c (code): r0: 1,2,3,11; r1: 4,5,6,12; r2: 7,8,9,13; r3: none(0),10,15,14.
REQ-014 Frame candidate SHALL be the code of the first pressed mapped key in row-major order (r0c0 first), or 0 if none pressed; the unmapped key SHALL be ignored.
REQ-015 Candidate SHALL be evaluated on the clock after the column-3 sample.
REQ-016 Debounce FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; a match counter counts identical frames.
REQ-017 RELEASED: nonzero candidate -> PRESS_WAIT, store candidate, match=1; zero candidate -> stay.
REQ-018 PRESS_WAIT: candidate equals stored -> match+1; match reaching DEBOUNCE_FRAMES -> PRESSED with key=stored, key_held=1, key_valid=1 for one cycle; different nonzero -> restart with new candidate, match=1; zero -> RELEASED.
REQ-019 PRESSED: zero candidate -> RELEASE_WAIT, match=1; nonzero candidate (same or different) -> stay, key unchanged.
REQ-020 RELEASE_WAIT: zero candidate -> match+1; match reaching DEBOUNCE_FRAMES -> RELEASED with key=0, key_held=0; nonzero candidate -> PRESSED, key unchanged.
REQ-021 With DEBOUNCE_FRAMES=1, acceptance SHALL occur on the first qualifying frame.
REQ-022 key SHALL change only on FSM transitions into PRESSED or RELEASED; a second key needs a full release first.
REQ-023 Press latency, from the first qualifying frame's evaluation to the key update: (DEBOUNCE_FRAMES-1) frames plus 1 clock.

Reset
REQ-024 On rst: col=1110, dwell=0, column index=0, synchronizer=1111, FSM=RELEASED, match=0, key=0, key_valid=0, key_held=0.
REQ-025 rst asserted mid-press SHALL discard state; after release of rst, the key SHALL be re-debounced from RELEASED.

Configuration
REQ-026 Macro KEYPAD_MULTIKEY_REJECT_EN: when defined, a frame with two or more pressed mapped keys SHALL yield candidate 0; when undefined, the priority rule of REQ-014 SHALL apply.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=2)
REQ-027 Reset, no keys -> col cycles 1110,1101,1011,0111 every 4 clocks; key=0, key_valid never set.
REQ-028 Hold r1c2 steady -> key=6 and key_held=1 after the 2nd frame evaluation; key_valid high for exactly one cycle.
REQ-029 r3c3 pressed for 1 frame only (bounce) -> key stays 0; pressed for 2 frames -> key=14.
REQ-030 Press r0c0, then release for 1 frame, then press again -> key stays 1; release for 2 frames -> key=0, key_held=0.
REQ-031 r0c1 and r2c3 held together -> macro undefined: key=2; macro defined: key=0.
REQ-032 rst asserted while r2c0 is accepted (key=7) -> next clock key=0 and col=1110; key held through -> key=7 again after 2 frames.
